sha3_absorb_padder: RTL and testbench

Message-block assembler in front of the Keccak-f[1600] permutation core. It accepts the message as a stream of 64-bit words, applies SHA-3 domain padding (0x06 … 0x80) to the final partial word, and zero-fills the remaining lanes. It presents one rate-sized block at a time to the permutation core, using a full/ack handshake. Byte order within a word is MSB-first: byte 0 is `in[63:56]`.

---
 rtl/sha3_pkg.sv | 19 +
 rtl/padder1.sv | 23 ++
 rtl/sha3_absorb_padder.sv | 107 ++++++++++
 tb/tb_sha3_absorb_padder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants: rate per variant, padding byte/bit positions and
// the absorb-side FSM state encoding.
package sha3_pkg;

  localparam int RATE_WORDS_SHA3_512 = 9;
  localparam int RATE_WORDS_SHA3_384 = 13;
  localparam int RATE_WORDS_SHA3_256 = 17;
  localparam int RATE_WORDS_SHA3_224 = 18;

  localparam logic [7:0] DOMAIN_BYTE = 8'h06;
  localparam int         FINAL_BIT   = 7;

  typedef enum logic [1:0] {
    ABSORB = 2'd0,
    PAD    = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/padder1.sv
// Combinational byte-padder for the final message word: keeps bytes
// 0..byte_num-1 (byte 0 at the MSBs), inserts the domain byte, zeroes the rest.
module padder1
  import sha3_pkg::*;
(
  input  logic [63:0] in,
  input  logic [2:0]  byte_num,
  output logic [63:0] out
);

  always_comb begin
    // NOTE: out gets a full default before the loop so no path leaves it unassigned (no latch).
    out = in;
    for (int i = 0; i < 8; i++) begin
      if (i == int'(byte_num)) begin
        out[63-8*i -: 8] = DOMAIN_BYTE;
      end else if (i > int'(byte_num)) begin
        out[63-8*i -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha3_absorb_padder.sv
// Assembles 64-bit message words into rate-sized blocks for Keccak-f[1600],
// applying SHA-3 padding and zero-filling the tail lanes of the last block.
module sha3_absorb_padder
  import sha3_pkg::*;
#(
  parameter int RATE_WORDS = RATE_WORDS_SHA3_512,
  parameter int CNT_W      = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init,
  input  logic [63:0]               in,
  input  logic                      in_ready,
  input  logic                      is_last,
  input  logic [2:0]                byte_num,
  output logic                      buffer_full,
  output logic [64*RATE_WORDS-1:0]  out,
  input  logic                      f_ack,
  output logic                      done
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_WORDS - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      full_q, full_d;
  logic [64*RATE_WORDS-1:0]  out_q, out_d;

  logic [63:0] pad_w;
  logic [63:0] w;
  logic        accept;
  logic        fill;
  logic        update;
  logic        last_lane;

  padder1 u_padder1 (
    .in       (in),
    .byte_num (byte_num),
    .out      (pad_w)
  );

  always_comb begin
    accept    = in_ready && !full_q && (state_q == ABSORB);
    fill      = (state_q == PAD) && !full_q;
    update    = accept || fill;
    last_lane = (cnt_q == LAST_LANE);

    w = '0;
    if (state_q == ABSORB) begin
      w = is_last ? pad_w : in;
    end
    // The closing pad10*1 bit lands in whichever lane ends the block.
    if (last_lane && ((state_q == PAD) || is_last)) begin
      w[FINAL_BIT] = 1'b1;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    out_d   = out_q;

    if (update) begin
      out_d = {out_q[64*(RATE_WORDS-1)-1:0], w};
      cnt_d = cnt_q + 1'b1;
      if (last_lane) begin
        full_d = 1'b1;
      end
    end else if (f_ack && full_q) begin
      full_d = 1'b0;
      cnt_d  = '0;
    end

    case (state_q)
      ABSORB:  if (accept && is_last) state_d = last_lane ? DONE : PAD;
      PAD:     if (fill && last_lane) state_d = DONE;
      default: state_d = state_q;
    endcase

    if (init) begin
      state_d = ABSORB;
      cnt_d   = '0;
      full_d  = 1'b0;
      out_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ABSORB;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      // NOTE: the wide block register is reset too, since a cleared out is observable after reset.
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      out_q   <= out_d;
    end
  end

  assign buffer_full = full_q;
  assign out         = out_q;
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_sha3_absorb_padder.sv
// Scoreboard bench: a byte-stream SHA-3 padding model predicts each block,
// a monitor compares whenever buffer_full rises.
module tb_sha3_absorb_padder;

  localparam int R  = 9;
  localparam int BW = 64 * R;
  localparam int RB = 8 * R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic [63:0]   in_w = '0;
  logic          in_ready = 1'b0;
  logic          is_last = 1'b0;
  logic [2:0]    byte_num = '0;
  logic          buffer_full;
  logic [BW-1:0] out_w;
  logic          f_ack = 1'b0;
  logic          done;

  typedef struct {
    logic [BW-1:0] blk;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] msg_words[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic        mon_prev_full = 1'b0;

  sha3_absorb_padder #(.RATE_WORDS(R), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (init),
    .in          (in_w),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out_w),
    .f_ack       (f_ack),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_out"},  out_w, '0);
    check({name, "_full"}, BW'(buffer_full), '0);
    check({name, "_done"}, BW'(done), '0);
  endtask

  // Reference: message bytes ++ 0x06 ++ zeros up to a rate multiple, last byte |= 0x80.
  task automatic push_expect(input logic [63:0] last_w, input logic [2:0] bn);
    logic [7:0] bq[$];
    int nblk;
    exp_t e;
    foreach (msg_words[k])
      for (int b = 0; b < 8; b++) bq.push_back(msg_words[k][63-8*b -: 8]);
    for (int b = 0; b < int'(bn); b++) bq.push_back(last_w[63-8*b -: 8]);
    bq.push_back(8'h06);
    while (bq.size() % RB != 0) bq.push_back(8'h00);
    bq[bq.size()-1] = bq[bq.size()-1] | 8'h80;
    nblk = bq.size() / RB;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int i = 0; i < RB; i++) e.blk[BW-1-8*i -: 8] = bq[b*RB+i];
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [63:0] w, input logic last, input logic [2:0] bn);
    int guard = 0;
    @(negedge clk);
    in_w = w; in_ready = 1'b1; is_last = last; byte_num = bn;
    while (buffer_full && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (buffer_full) begin
      fail_timeout("accept_wait");
      in_ready = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_ready = 1'b0; is_last = 1'b0;
    end
  endtask

  task automatic run_message(input logic [63:0] last_w, input logic [2:0] bn, input bit spurious);
    int guard;
    push_expect(last_w, bn);
    foreach (msg_words[k]) begin
      send_word(msg_words[k], 1'b0, 3'd0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    send_word(last_w, 1'b1, bn);
    guard = 0;
    @(negedge clk);
    while (!done && guard < 64) begin
      in_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      in_w     = {$urandom, $urandom};
      is_last  = 1'($urandom_range(0, 1));
      byte_num = 3'($urandom_range(0, 7));
      @(negedge clk);
      guard++;
    end
    in_ready = 1'b0; is_last = 1'b0;
    if (!done) fail_timeout("done_wait");
    if ($urandom_range(0, 1) == 1) begin
      guard = 0;
      while (buffer_full && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (buffer_full) fail_timeout("ack_wait");
    end
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    check_cleared("init");
  endtask

  // Monitor: compare one expected block on each rising edge of buffer_full.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev_full = 1'b0;
      end else begin
        if (buffer_full && !mon_prev_full) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_block: got %h expected no block", out_w);
          end else begin
            e = exp_q.pop_front();
            check("block", out_w, e.blk);
            check("done_with_block", BW'(done), BW'(e.last));
          end
        end
        mon_prev_full = buffer_full;
      end
    end
  end

  // Permutation-core stand-in: random-latency acks, occasional ignored acks while idle.
  initial begin
    forever begin
      @(negedge clk);
      if (buffer_full) f_ack = ($urandom_range(0, 2) == 0);
      else             f_ack = ($urandom_range(0, 9) == 0);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_cleared("reset");
    @(negedge clk) rst_n = 1'b1;

    // Ten words then an empty last word: second block is pure padding after 0xA.
    msg_words.delete();
    for (int i = 1; i <= 10; i++) msg_words.push_back(64'(i));
    run_message(64'h0, 3'd0, 1'b0);

    // Partial last word mid-block, with ignored in_ready pulses during PAD.
    msg_words.delete();
    repeat (2) msg_words.push_back({$urandom, $urandom});
    run_message(64'hAABBCCDDEEFF0011, 3'd3, 1'b1);

    // Last word with 7 bytes lands in the final lane.
    msg_words.delete();
    repeat (8) msg_words.push_back({$urandom, $urandom});
    run_message(64'h1122334455667788, 3'd7, 1'b0);

    // Empty last word in the final lane.
    msg_words.delete();
    repeat (8) msg_words.push_back({$urandom, $urandom});
    run_message({$urandom, $urandom}, 3'd0, 1'b0);

    // Message is exactly one rate long.
    msg_words.delete();
    repeat (9) msg_words.push_back({$urandom, $urandom});
    run_message({$urandom, $urandom}, 3'd0, 1'b1);

    for (int m = 0; m < 20; m++) begin
      msg_words.delete();
      repeat ($urandom_range(0, 30)) msg_words.push_back({$urandom, $urandom});
      run_message({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of PAD.
    send_word({$urandom, $urandom}, 1'b0, 3'd0);
    send_word({$urandom, $urandom}, 1'b0, 3'd0);
    send_word(64'hAABBCCDDEEFF0011, 1'b1, 3'd3);
    #1 in_ready = 1'b0; is_last = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_cleared("async_reset");
    @(negedge clk) rst_n = 1'b1;

    // Fresh message after reset.
    msg_words.delete();
    repeat (5) msg_words.push_back({$urandom, $urandom});
    run_message({$urandom, $urandom}, 3'd5, 1'b0);

    idle(2);
    check("scoreboard_drained", BW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
